// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin shared register array with a sequenced bulk-clear sweep.
// One read or write is granted per cycle; reads respond one cycle after the grant.
module regfile_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = 8'hA0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      clear_start,
  output logic                      busy
);
  localparam int PTR_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic rsp_valid_q;
  logic [2:0] rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic grant, g_write;
  logic [PTR_W-1:0] gnt_idx, idx;
  logic [PTR_W:0] sum;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  // Rotating scan from rr_ptr; a clear request pre-empts any grant that cycle.
  always_comb begin
    grant = 1'b0;
    gnt_idx = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      sum = (sum >= (PTR_W+1)'(NUM_REQ)) ? sum - (PTR_W+1)'(NUM_REQ) : sum;
      idx = sum[PTR_W-1:0];
      if (!grant && req_valid[idx] && state_q == IDLE && !clear_start) begin
        grant = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign g_write = req_write[gnt_idx];
  assign g_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign g_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign req_ready = grant ? NUM_REQ'(1) << gnt_idx : '0;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? (clear_start ? CLEAR : IDLE)
                              : (cnt_q == ADDR_W'(DEPTH-1) ? IDLE : CLEAR);
    cnt_d = state_q == CLEAR ? cnt_q + 1'b1 : '0;
    rr_ptr_d = !grant ? rr_ptr_q : (gnt_idx == PTR_W'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1);
  end
  always_comb busy = state_q == CLEAR;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
    end else begin
      if (state_q == CLEAR) mem_q[cnt_q] <= RESET_VAL;
      else if (grant && g_write) mem_q[g_addr] <= g_wdata;
      rsp_valid_q <= grant && !g_write;
      if (grant && !g_write) begin
        rsp_id_q <= 3'(gnt_idx);
        rsp_data_q <= mem_q[g_addr];
      end
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: randomized and directed stimulus against a behavioural model,
// with read responses checked by an independent scoreboard monitor.
module tb_regfile_arbiter;
  localparam int N = 4;
  localparam int DEPTH = 16;
  localparam logic [7:0] RV = 8'hA0;
  logic clock = 0, reset = 1;
  logic [N-1:0] req_valid = '0, req_write = '0, req_ready;
  logic [N*4-1:0] req_addr = '0;
  logic [N*8-1:0] req_wdata = '0;
  logic rsp_valid, clear_start = 0, busy;
  logic [2:0] rsp_id;
  logic [7:0] rsp_data;
  regfile_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .clear_start(clear_start), .busy(busy)
  );
  always #5 clock = ~clock;
  typedef struct {int due; int id; logic [7:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;
  int glog[$];
  int passed = 0, total = 0, cyc = 0;
  bit pv[N], pw[N], clr;
  logic [3:0] pa[N];
  logic [7:0] pd[N];
  logic [7:0] mem[DEPTH];
  int rr = 0, clr_left = 0;
  logic dut_busy;
  logic [N-1:0] dut_rdy;
  task automatic check(string n, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, x, cyc);
    else passed++;
  endtask
  always @(posedge clock) cyc++;
  always @(negedge clock)
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, e.id);
        check("rsp_data", rsp_data, e.data);
      end else check("rsp_valid_idle", rsp_valid, 0);
    end
  task automatic cycle();
    int g;
    logic [N-1:0] xr;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pv[i];
      req_write[i] = pw[i];
      req_addr[i*4 +: 4] = pa[i];
      req_wdata[i*8 +: 8] = pd[i];
    end
    clear_start = clr;
    #1;
    dut_busy = busy;
    dut_rdy = req_ready;
    g = -1;
    if (clr_left == 0 && !clr)
      for (int k = 0; k < N; k++) if (g < 0 && pv[(rr + k) % N]) g = (rr + k) % N;
    xr = (g < 0) ? '0 : N'(1 << g);
    check("req_ready", req_ready, xr);
    check("busy", busy, clr_left > 0);
    if (g >= 0) begin
      glog.push_back(g);
      if (pw[g]) mem[pa[g]] = pd[g];
      else sb.push_back('{cyc + 1, g, mem[pa[g]]});
      pv[g] = 0;
      rr = (g + 1) % N;
    end
    if (clr_left > 0) clr_left--;
    else if (clr) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = RV;
    end
    clr = 0;
  endtask
  task automatic issue(int r, bit w, int a, logic [7:0] d);
    int n = 0;
    pv[r] = 1; pw[r] = w; pa[r] = 4'(a); pd[r] = d;
    while (pv[r] && n < 40) begin
      cycle();
      n++;
    end
    check("issue_timeout", pv[r], 0);
    pv[r] = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((pv[0] | pv[1] | pv[2] | pv[3]) && n < 60) begin
      cycle();
      n++;
    end
    check("drain_timeout", {pv[0], pv[1], pv[2], pv[3]}, 0);
    repeat (3) cycle();
  endtask
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset = 1;
    req_valid = '0;
    clear_start = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req_ready", req_ready, 0);
    for (int i = 0; i < N; i++) pv[i] = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = RV;
    rr = 0; clr_left = 0; clr = 0;
    sb.delete();
    @(negedge clock);
    #2 reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, bc;
    do_reset();
    // Reads of reset contents, then write-then-read across requesters.
    issue(0, 0, 0, 0);
    issue(0, 0, 15, 0);
    issue(1, 1, 5, 8'h3C);
    issue(2, 0, 5, 0);
    issue(3, 0, 5, 0);
    repeat (2) cycle();
    check("rr_start_grant", glog[glog.size()-1], 3);
    // All requesters continuously valid: strict rotation.
    base = glog.size();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i]) begin pv[i] = 1; pw[i] = 0; pa[i] = 4'($urandom_range(0, 15)); end
      cycle();
    end
    for (int j = 0; j < 8; j++) check("rotation", glog[base + j], j % N);
    drain();
    // Wrap from requester 3 back to 0.
    pv[3] = 1; pw[3] = 0; pa[3] = 4'd1;
    cycle();
    check("wrap_first", glog[glog.size()-1], 3);
    pv[3] = 1; pa[3] = 4'd2;
    pv[0] = 1; pw[0] = 0; pa[0] = 4'd3;
    cycle();
    check("wrap_second", glog[glog.size()-1], 0);
    cycle();
    check("wrap_third", glog[glog.size()-1], 3);
    drain();
    // Fill with 8'h55 then sweep with a request pending in the start cycle.
    for (int a = 0; a < DEPTH; a++) issue(a % N, 1, a, 8'h55);
    pv[1] = 1; pw[1] = 0; pa[1] = 4'd3;
    clr = 1;
    cycle();
    check("clear_start_no_grant", dut_rdy, 0);
    bc = 0;
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (dut_busy) bc++;
    end
    check("busy_cycles", bc, DEPTH);
    drain();
    for (int a = 0; a < DEPTH; a++) issue($urandom_range(0, N-1), 0, a, 0);
    drain();
    // Reset in the middle of a sweep.
    issue(0, 1, 0, 8'h77);
    issue(1, 1, 12, 8'h77);
    clr = 1;
    cycle();
    repeat (7) cycle();
    check("mid_sweep_busy", dut_busy, 1);
    do_reset();
    pv[2] = 1; pw[2] = 0; pa[2] = 4'd0;
    pv[3] = 1; pw[3] = 0; pa[3] = 4'd12;
    cycle();
    check("post_reset_grant", dut_rdy, 4'b0100);
    drain();
    // Randomized traffic with occasional sweeps.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 4'($urandom_range(0, 15));
          pd[i] = 8'($urandom);
        end
      if (clr_left == 0 && $urandom_range(0, 79) == 0) clr = 1;
      cycle();
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Owns a DEPTH x DATA_W register array and shares it between NUM_REQ requesters.
- One access (read or write) is granted per cycle, using round-robin priority.
- Includes a sequenced bulk-clear engine that sweeps every entry back to RESET_VAL.
- Sits between the control units and the shared register storage; nothing else accesses the array directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DEPTH, 16, number of array entries
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W
- DATA_W, 8, entry width
- RESET_VAL, 8'hA0, value loaded into every entry by reset and by a clear sweep

Ports:
- clock  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester access request
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr
- req_ready  out  NUM_REQ  one-hot grant; the access completes in this cycle
- rsp_valid  out  1  read data valid
- rsp_id  out  3  requester index that owns rsp_data
- rsp_data  out  DATA_W  read data
- clear_start  in  1  single-cycle pulse; starts a clear sweep
- busy  out  1  high while a clear sweep is running

Behaviour:
- Reset (asynchronous):
  - every array entry = RESET_VAL
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0
  - state = IDLE, rr_ptr = 0, clear counter = 0
- Handshake:
  - A requester holds valid/write/addr/wdata stable until it sees req_ready high.
  - The access happens in the cycle where req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, rr_ptr and state. It is never asserted for a requester whose valid is low.
- Arbitration (IDLE only):
  - Scan requesters starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first requester with valid high is granted.
  - After a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Write: array[addr] <= wdata at the granting edge.
- Read latency is 1 cycle:
  - The cycle after a read grant, rsp_valid = 1, rsp_id = g, rsp_data = array[addr] sampled at the grant edge.
  - rsp_valid is high for exactly one cycle per read grant.
  - Back-to-back reads give back-to-back responses.
  - A write granted in cycle N is visible to a read granted in cycle N+1.
- State machine:
  - IDLE -> CLEAR when clear_start = 1. The clear counter is loaded with 0 and no grant is issued in that cycle (clear has priority over requests).
  - CLEAR: each cycle, array[counter] <= RESET_VAL and counter increments. busy = 1 and req_ready = 0 throughout.
  - CLEAR -> IDLE after the cycle that writes entry DEPTH-1, so a sweep lasts exactly DEPTH cycles.
  - busy is registered: it goes high the cycle after clear_start and low the cycle after the last entry is written.
  - clear_start while in CLEAR is ignored; the sweep is not restarted.
  - rr_ptr holds during CLEAR.
  - A read response owed from a grant issued in the clear_start cycle's predecessor is still delivered.
- Reset mid-sweep: returns to IDLE immediately, and all entries = RESET_VAL.
- Width rules:
  - Addresses are used unmodified and are always in range, because DEPTH = 2**ADDR_W.
  - Unused rsp_id bits are 0.

Test Plan:
- Reset, then reads by requester 0 of addr 0 and addr 15 -> rsp_data = 8'hA0 both times, rsp_id = 0, each response one cycle after its grant.
- Requester 1 writes 8'h3C to addr 5; next cycle requester 2 reads addr 5 -> rsp_valid one cycle after the read grant, rsp_id = 2, rsp_data = 8'h3C.
- All 4 requesters hold valid for 8 cycles starting with rr_ptr = 0 -> grants in order 0,1,2,3,0,1,2,3, exactly one per cycle, none skipped.
- Only requester 3 valid, then requesters 3 and 0 valid together -> grants 3 then 0 (rr_ptr wraps from 3 to 0).
- Write 8'h55 to addrs 0..15, pulse clear_start together with a pending request -> no grant that cycle, busy high for 16 cycles, req_ready = 0 throughout, every subsequent read returns 8'hA0.
- Start a sweep, assert reset at sweep cycle 7, release reset -> busy = 0, state IDLE, reads of addr 0 and addr 12 return 8'hA0, and a new grant is issued on the first cycle after reset deasserts.
